// File: rtl/axi4l_reg_slave.sv
// axi4l_reg_slave: AXI4-Lite register bank slave; define AXI4L_REG_SLAVE_DECERR_EN for DECERR on out-of-range access
module axi4l_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(SW);
`ifdef AXI4L_REG_SLAVE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif
  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  wr_state_t wr_state;
  rd_state_t rd_state;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] addr_q, c_addr, c_word, ar_word;
  logic [DATA_WIDTH-1:0] data_q, c_data, rd_val;
  logic [SW-1:0]         strb_q, c_strb;
  logic aw_hs, w_hs, ar_hs, have_a, have_d, commit, c_hit, ar_hit;
  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};
  assign aw_hs = awvalid && awready;
  assign w_hs = wvalid && wready;
  assign ar_hs = arvalid && arready;
  // a commit needs the address and data either arriving now or already latched
  assign have_a = aw_hs || wr_state == WR_HAVE_ADDR;
  assign have_d = w_hs || wr_state == WR_HAVE_DATA;
  assign commit = have_a && have_d;
  assign c_addr = aw_hs ? awaddr : addr_q;
  assign c_data = w_hs ? wdata : data_q;
  assign c_strb = w_hs ? wstrb : strb_q;
  assign c_word = c_addr >> ADDR_LSB;
  assign c_hit = c_word < ADDR_WIDTH'(NUM_REGS);
  assign ar_word = araddr >> ADDR_LSB;
  assign ar_hit = ar_word < ADDR_WIDTH'(NUM_REGS);
  always_comb begin
    rd_val = '0;
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_word == ADDR_WIDTH'(i)) rd_val = regs[i];
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end
  always_ff @(posedge aclk)
    if (areset) begin
      wr_state <= WR_IDLE;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bresp <= 2'b00;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (aw_hs) addr_q <= awaddr;
      if (w_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
      if (wr_state == WR_RESP) begin
        if (bready) begin
          wr_state <= WR_IDLE;
          bvalid <= 1'b0;
          awready <= 1'b1;
          wready <= 1'b1;
        end
      end else begin
        wr_state <= commit ? WR_RESP : have_a ? WR_HAVE_ADDR : have_d ? WR_HAVE_DATA : WR_IDLE;
        awready <= !have_a;
        wready <= !have_d;
        bvalid <= commit;
        if (commit) bresp <= c_hit ? 2'b00 : OOR_RESP;
      end
    end
  always_ff @(posedge aclk)
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      reg_wr_pulse <= '0;
    end else
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= commit && c_word == ADDR_WIDTH'(i);
        for (int b = 0; b < SW; b++)
          if (commit && c_word == ADDR_WIDTH'(i) && c_strb[b]) regs[i][8*b +: 8] <= c_data[8*b +: 8];
      end
  always_ff @(posedge aclk)
    if (areset) begin
      rd_state <= RD_IDLE;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rdata <= '0;
      rresp <= 2'b00;
    end else if (rd_state == RD_IDLE) begin
      arready <= !ar_hs;
      if (ar_hs) begin
        rd_state <= RD_DATA;
        rvalid <= 1'b1;
        rdata <= rd_val;
        rresp <= ar_hit ? 2'b00 : OOR_RESP;
      end
    end else if (rready) begin
      rd_state <= RD_IDLE;
      rvalid <= 1'b0;
      arready <= 1'b1;
    end
endmodule

// File: tb/tb_axi4l_reg_slave.sv
// tb_axi4l_reg_slave: directed and random AXI4-Lite traffic checked against a register-array model
`define CHK(t, o, e) chk(t, 256'(o), 256'(e))
module tb_axi4l_reg_slave;
`ifdef AXI4L_REG_SLAVE_DECERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  logic aclk = 1'b0, areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [255:0] reg_out;
  logic [7:0] reg_wr_pulse;
  logic [31:0] mdl [8];
  int checks = 0, failures = 0;

  axi4l_reg_slave dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_out();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = mdl[i];
    return r;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    logic aw_done, w_done, hs_aw, hs_w;
    logic [7:0] ep;
    logic [1:0] er;
    int cyc, idx;
    aw_done = 1'b0;
    w_done = 1'b0;
    cyc = 0;
    idx = int'(a >> 2);
    while (!(awready && wready) && cyc < 20) begin
      step();
      cyc++;
    end
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 30) begin
      awaddr = a;
      wdata = d;
      wstrb = s;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid = !w_done && cyc >= w_dly;
      hs_aw = awvalid && awready;
      hs_w = wvalid && wready;
      step();
      aw_done = aw_done | hs_aw;
      w_done = w_done | hs_w;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    `CHK("wr_handshake", aw_done && w_done, 1'b1);
    if (idx < 8) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx[2:0]][8*b +: 8] = d[8*b +: 8];
      ep = 8'(1 << idx);
      er = 2'b00;
    end else begin
      ep = 8'h00;
      er = ERR;
    end
    `CHK("bvalid_rise", bvalid, 1'b1);
    `CHK("bresp", bresp, er);
    `CHK("wr_pulse", reg_wr_pulse, ep);
    `CHK("reg_out", reg_out, model_out());
    `CHK("wr_readies_in_resp", {awready, wready}, 2'b00);
    repeat (b_dly) begin
      step();
      `CHK("bvalid_hold", bvalid, 1'b1);
      `CHK("bresp_hold", bresp, er);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    `CHK("bvalid_fall", bvalid, 1'b0);
    `CHK("wr_pulse_once", reg_wr_pulse, 8'h00);
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly);
    logic [31:0] ed;
    logic [1:0] er;
    int n, idx;
    idx = int'(a >> 2);
    ed = idx < 8 ? mdl[idx[2:0]] : 32'h0;
    er = idx < 8 ? 2'b00 : ERR;
    araddr = a;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      step();
      n++;
    end
    `CHK("ar_wait", arready, 1'b1);
    step();
    arvalid = 1'b0;
    `CHK("rvalid_latency", rvalid, 1'b1);
    `CHK("rdata", rdata, ed);
    `CHK("rresp", rresp, er);
    `CHK("arready_busy", arready, 1'b0);
    repeat (r_dly) begin
      step();
      `CHK("rvalid_hold", rvalid, 1'b1);
      `CHK("rdata_hold", rdata, ed);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    `CHK("rvalid_fall", rvalid, 1'b0);
  endtask

  initial begin
    logic [31:0] old;
    int n;
    areset = 1'b1;
    {awvalid, wvalid, bready, arvalid, rready} = '0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    repeat (3) step();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      failures++;
      $error("FAIL rst_handshakes");
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      failures++;
      $error("FAIL rst_resp_data");
    end
    checks++;
    if (reg_wr_pulse !== 8'h00) begin
      failures++;
      $error("FAIL rst_pulse");
    end
    checks++;
    if (reg_out !== 256'h0) begin
      failures++;
      $error("FAIL rst_regs");
    end
    areset = 1'b0;
    for (int i = 0; i < 8; i++) axi_read(32'(i * 4), 0);
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    axi_read(32'h08, 1);
    axi_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(32'h0C, 32'h12345678, 4'b0101, 0, 3, 0);
    `CHK("reg3_merge", reg_out[127:96], 32'hFF34FF78);
    axi_read(32'h0C, 0);
    axi_write(32'h10, 32'hCAFEF00D, 4'hF, 2, 0, 4);
    axi_read(32'h10, 2);
    axi_read(32'h20, 0);
    axi_write(32'h20, 32'h11111111, 4'hF, 0, 0, 1);
    axi_read(32'h1000_0008, 0);
    axi_write(32'h1000_0008, 32'h22222222, 4'hF, 1, 0, 0);
    axi_write(32'h08, 32'h0, 4'h0, 0, 0, 0);
    axi_write(32'h07, 32'hA1B2C3D4, 4'hF, 0, 1, 0);
    axi_read(32'h06, 0);
    axi_write(32'h14, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    `CHK("idle_readies", {awready, wready, arready}, 3'b111);
    old = mdl[5];
    awaddr = 32'h14; wdata = 32'h5A5A5A5A; wstrb = 4'hF; araddr = 32'h14;
    {awvalid, wvalid, arvalid} = 3'b111;
    step();
    {awvalid, wvalid, arvalid} = 3'b000;
    mdl[5] = 32'h5A5A5A5A;
    checks++;
    if (rdata !== old) begin
      failures++;
      $error("FAIL same_edge_rdata observed=%0h expected=%0h", rdata, old);
    end
    checks++;
    if ({bvalid, rvalid} !== 2'b11) begin
      failures++;
      $error("FAIL same_edge_valids");
    end
    checks++;
    if (reg_wr_pulse !== 8'h20) begin
      failures++;
      $error("FAIL same_edge_pulse observed=%0h", reg_wr_pulse);
    end
    checks++;
    if (reg_out !== model_out()) begin
      failures++;
      $error("FAIL same_edge_reg");
    end
    {bready, rready} = 2'b11;
    step();
    {bready, rready} = 2'b00;
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin
      failures++;
      $error("FAIL same_edge_done");
    end
    awaddr = 32'h04; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin
      step();
      n++;
    end
    step();
    awvalid = 1'b0;
    `CHK("have_addr_readies", {awready, wready}, 2'b01);
    araddr = 32'h0; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    `CHK("rd_pending", rvalid, 1'b1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    `CHK("mid_rst_handshakes", {awready, wready, arready, bvalid, rvalid}, 5'b0);
    `CHK("mid_rst_regs", reg_out, 256'h0);
    `CHK("mid_rst_pulse", reg_wr_pulse, 8'h00);
    axi_write(32'h04, 32'h0BADC0DE, 4'hF, 0, 1, 0);
    axi_read(32'h04, 0);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)), $urandom, 4'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      else
        axi_read(32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
    checks++;
    if (reg_out !== model_out()) begin
      failures++;
      $error("FAIL final_regs");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
